// File: rtl/mem_stall_responder.sv
// Serialises CPU dcache/icache accesses onto one backing-memory port and stalls the CPU while any are outstanding.
// Optional feature macro LINE_BUF_EN: one-entry fetch buffer that answers repeat fetches without stalling.
module mem_stall_responder #(
    parameter int ADDR_W      = 28,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dcache_addr,
    input  logic [3:0]        dcache_we,
    input  logic              dcache_re,
    input  logic [31:0]       dcache_din,
    output logic [31:0]       dcache_dout,
    input  logic [31:0]       icache_addr,
    input  logic [3:0]        icache_we,
    input  logic              icache_re,
    input  logic [31:0]       icache_din,
    output logic [31:0]       instruction,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rnw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_rdata,
    output logic              timeout_err
);
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 10) ? $clog2(TIMEOUT_CYC + 1) : 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state, state_nxt;

    // Pending phases in service order: bit0 D_WR, bit1 I_WR, bit2 D_RD, bit3 I_RD.
    logic [3:0]        pend;
    logic [3:0]        cur;
    logic [3:0]        req_flags;
    logic [ADDR_W-1:2] d_addr, i_addr;
    logic [31:0]       d_wdata, i_wdata;
    logic [3:0]        d_mask, i_mask;
    logic [CNT_W-1:0]  cnt;
    logic              cur_rd, req_fire, resp_fire, tmo, phase_done;
    logic              buf_hit;
    logic [31:0]       hit_data;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{dcache_addr[31:ADDR_W], dcache_addr[1:0],
                                icache_addr[31:ADDR_W], icache_addr[1:0]};

    assign req_flags = {icache_re, dcache_re, |icache_we, |dcache_we};
    assign cur       = pend & (~pend + 4'd1);
    assign cur_rd    = cur[2] | cur[3];

    assign req_fire   = (state == ISSUE) && mem_req_ready;
    assign resp_fire  = (state == WAIT) && mem_resp_valid;
    assign tmo        = (((state == ISSUE) && !mem_req_ready) ||
                         ((state == WAIT) && !mem_resp_valid)) && (cnt == CNT_LAST);
    assign phase_done = (req_fire && !cur_rd) || resp_fire || tmo;

    assign stall         = (state != IDLE);
    assign mem_req_valid = (state == ISSUE);
    assign mem_req_rnw   = cur_rd;
    assign mem_req_addr  = {((cur[0] | cur[2]) ? d_addr : i_addr), 2'b00};
    assign mem_req_wdata = cur[0] ? d_wdata : i_wdata;
    assign mem_req_wmask = cur_rd ? 4'hF : (cur[0] ? d_mask : i_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|req_flags && !buf_hit) state_nxt = ISSUE;
            end
            ISSUE, WAIT: begin
                if (phase_done)    state_nxt = |(pend & ~cur) ? ISSUE : IDLE;
                else if (req_fire) state_nxt = WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend        <= '0;
            cnt         <= '0;
            d_addr      <= '0;
            i_addr      <= '0;
            d_wdata     <= '0;
            i_wdata     <= '0;
            d_mask      <= '0;
            i_mask      <= '0;
            dcache_dout <= '0;
            instruction <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo;
            if (state == IDLE) begin
                pend    <= buf_hit ? 4'b0000 : req_flags;
                cnt     <= '0;
                d_addr  <= dcache_addr[ADDR_W-1:2];
                i_addr  <= icache_addr[ADDR_W-1:2];
                d_wdata <= dcache_din;
                i_wdata <= icache_din;
                d_mask  <= dcache_we;
                i_mask  <= icache_we;
                if (buf_hit) instruction <= hit_data;
            end else begin
                if (phase_done) pend <= pend & ~cur;
                // Counter restarts on every handshake so each leg gets its own budget.
                cnt <= (phase_done || req_fire) ? '0 : cnt + CNT_W'(1);
                if (phase_done && cur[2]) dcache_dout <= tmo ? TIMEOUT_DATA : mem_resp_rdata;
                if (phase_done && cur[3]) instruction <= tmo ? TIMEOUT_DATA : mem_resp_rdata;
            end
        end
    end

`ifdef LINE_BUF_EN
    logic        lb_vld;
    logic [29:0] lb_addr;
    logic [31:0] lb_data;
    logic [29:0] fetch_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lb_vld     <= 1'b0;
            lb_addr    <= '0;
            lb_data    <= '0;
            fetch_addr <= '0;
        end else begin
            if (state == IDLE) fetch_addr <= icache_addr[31:2];
            // Any write may alias the buffered word, so drop it rather than compare.
            if ((state == IDLE) && (req_flags[0] || req_flags[1])) begin
                lb_vld <= 1'b0;
            end else if (tmo) begin
                lb_vld <= 1'b0;
            end else if (phase_done && cur[3]) begin
                lb_vld  <= 1'b1;
                lb_addr <= fetch_addr;
                lb_data <= mem_resp_rdata;
            end
        end
    end

    assign buf_hit  = (state == IDLE) && (req_flags == 4'b1000) && lb_vld &&
                      (lb_addr == icache_addr[31:2]);
    assign hit_data = lb_data;
`else
    assign buf_hit  = 1'b0;
    assign hit_data = 32'h0;
`endif

endmodule
